// File: rtl/alu_pkg.sv
// Shared ALU definitions for the signed-magnitude units (add_sub, sm_divider):
// FSM state encoding, default operand width and sign normalisation.
package alu_pkg;

  // Default operand width including the sign bit.
  localparam int SM_DEFAULT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns the sign bit to emit for a signed-magnitude value: a zero
  // magnitude always carries sign 0, so -0 never leaves the ALU.
  function automatic logic sm_norm(input logic sign, input logic mag_zero);
    return sign & ~mag_zero;
  endfunction

endpackage

// File: rtl/sm_divider_if.sv
// Operand/result bundle of the signed-magnitude divider.
// master: the requester (ALU sequencer or bench); slave: the divider.
interface sm_divider_if #(parameter int W = 3);
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] REM;
  logic         SF;
  logic         DZF;
  logic         ZF;
  logic         busy;
  logic         done;

  modport master (
    output start, A, B,
    input  Q, REM, SF, DZF, ZF, busy, done
  );

  modport slave (
    input  start, A, B,
    output Q, REM, SF, DZF, ZF, busy, done
  );
endinterface

// File: rtl/sm_divider_div_step.sv
// One restoring-division iteration: shift {r, q} left by one, try to
// subtract the divisor from r, keep the difference and set q[0] when it
// does not go negative.
module div_step #(
  parameter int M = 2
) (
  input  logic [M:0]   r_i,
  input  logic [M-1:0] q_i,
  input  logic [M-1:0] d_i,
  output logic [M:0]   r_o,
  output logic [M-1:0] q_o
);

  logic [M+1:0] r_sh;
  logic [M+1:0] trial;
  logic         fits;

  // Trial subtraction one bit wider than r so its MSB is the borrow.
  always_comb begin
    r_sh  = {r_i, q_i[M-1]};
    trial = r_sh - {2'b00, d_i};
    fits  = ~trial[M+1];
    r_o   = fits ? trial[M:0] : r_sh[M:0];
    q_o   = (q_i << 1) | M'(fits);
  end

endmodule

// File: rtl/sm_divider.sv
// Sequential signed-magnitude restoring divider, one quotient bit per cycle,
// with start/busy/done handshake and SF/DZF/ZF flags matching add_sub.
// Optional macro DIV_EARLY_EXIT_EN: when |A| < |B| (including |A| == 0) the
// result is produced straight from IDLE instead of running the DIV cycles.
module sm_divider
  import alu_pkg::*;
#(
  parameter int W = SM_DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  sm_divider_if.slave    bus
);

  localparam int M  = W - 1;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [M:0]     r_q;
  logic [M-1:0]   q_q;
  logic [M-1:0]   d_q;
  logic           sa_q;
  logic           sb_q;

  logic [W-1:0]   q_res_q;
  logic [W-1:0]   rem_res_q;
  logic           sf_q;
  logic           dzf_q;
  logic           zf_q;

  logic [M:0]     r_next;
  logic [M-1:0]   q_next;
  logic [M-1:0]   a_mag;
  logic [M-1:0]   b_mag;
  logic           b_zero;
  logic           early;

  assign a_mag  = bus.A[M-1:0];
  assign b_mag  = bus.B[M-1:0];
  assign b_zero = (b_mag == '0);

`ifdef DIV_EARLY_EXIT_EN
  // Quotient is known to be zero without iterating.
  assign early = (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  div_step #(.M(M)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_next),
    .q_o (q_next)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = (b_zero || early) ? DONE : DIV;
      DIV:  if (cnt_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus.busy = (state_q == DIV);
    bus.done = (state_q == DONE);
  end

  // Operand latch, iteration datapath and result registers; results only
  // change on the edge that enters DONE and are held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      q_res_q   <= '0;
      rem_res_q <= '0;
      sf_q      <= 1'b0;
      dzf_q     <= 1'b0;
      zf_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            r_q   <= '0;
            q_q   <= a_mag;
            d_q   <= b_mag;
            sa_q  <= bus.A[M];
            sb_q  <= bus.B[M];
            cnt_q <= CW'(M - 1);
            if (b_zero) begin
              q_res_q   <= '0;
              rem_res_q <= '0;
              sf_q      <= 1'b0;
              dzf_q     <= 1'b1;
              zf_q      <= 1'b0;
            end else if (early) begin
              q_res_q   <= '0;
              rem_res_q <= {sm_norm(bus.A[M], a_mag == '0), a_mag};
              sf_q      <= 1'b0;
              dzf_q     <= 1'b0;
              zf_q      <= 1'b1;
            end
          end
        end
        DIV: begin
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            // Remainder is always below |B|, so it fits the magnitude field.
            q_res_q   <= {sm_norm(sa_q ^ sb_q, q_next == '0), q_next};
            rem_res_q <= {sm_norm(sa_q, r_next[M-1:0] == '0), r_next[M-1:0]};
            sf_q      <= sm_norm(sa_q ^ sb_q, q_next == '0);
            dzf_q     <= 1'b0;
            zf_q      <= (q_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Q   = q_res_q;
  assign bus.REM = rem_res_q;
  assign bus.SF  = sf_q;
  assign bus.DZF = dzf_q;
  assign bus.ZF  = zf_q;

endmodule
